// File: rtl/mmio_arbiter_pkg.sv
// Shared types for the MMIO arbiter: access size encoding and the
// sequencer state, which is also exported on the debug port.
package mmio_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HALF  = 2'd1,
        MEM_WORD  = 2'd2,
        MEM_DWORD = 2'd3
    } mem_access_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of one MMIO slave port.
// One access in flight at a time; a watchdog turns a hung slave into a fault.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      m0_addr_i,
    input  logic             m0_valid_i,
    input  mem_access_size_t m0_byte_en_i,
    input  logic             m0_wr_i,
    input  logic             m0_zero_extnd_i,
    input  logic [63:0]      m0_wr_data_i,
    output logic             m0_ready_o,
    output logic [63:0]      m0_data_o,
    output logic             m0_resp_valid_o,
    output logic             m0_exc_valid_o,
    output logic [4:0]       m0_exc_code_o,
    input  logic [63:0]      m1_addr_i,
    input  logic             m1_valid_i,
    input  mem_access_size_t m1_byte_en_i,
    input  logic             m1_wr_i,
    input  logic             m1_zero_extnd_i,
    input  logic [63:0]      m1_wr_data_i,
    output logic             m1_ready_o,
    output logic [63:0]      m1_data_o,
    output logic             m1_resp_valid_o,
    output logic             m1_exc_valid_o,
    output logic [4:0]       m1_exc_code_o,
    output logic [63:0]      s_addr_o,
    output logic             s_valid_o,
    output mem_access_size_t s_byte_en_o,
    output logic             s_wr_o,
    output logic             s_zero_extnd_o,
    output logic [63:0]      s_wr_data_o,
    input  logic             s_ready_i,
    input  logic [63:0]      s_data_i,
    input  logic             s_resp_valid_i,
    input  logic             s_exc_valid_i,
    input  logic [4:0]       s_exc_code_i,
    output arb_state_t       dbg_state_o
);
    // Handshake: a request transfers on a cycle where valid and ready are both
    // high; the slave request stays stable from s_valid_o rise until s_ready_i.
    arb_state_t       state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [7:0]       cnt_q;
    logic [63:0]      addr_q;
    mem_access_size_t be_q;
    logic             wr_q;
    logic             ze_q;
    logic [63:0]      wdata_q;
    logic             s_valid_q;
    logic             m0_resp_q, m0_exc_q, m1_resp_q, m1_exc_q;
    logic [63:0]      m0_data_q, m1_data_q;
    logic [4:0]       m0_code_q, m1_code_q;

    logic             idle;
    logic             grant0;
    logic             grant1;
    logic             slv_done;
    logic             timed_out;
    logic             fin_exc;
    logic [4:0]       fin_code;
    logic [63:0]      fin_data;

    // The master that did not win last time wins a tie.
    assign idle   = (state_q == ST_IDLE);
    assign grant0 = idle && m0_valid_i && (!m1_valid_i || last_grant_q);
    assign grant1 = idle && m1_valid_i && (!m0_valid_i || !last_grant_q);

    assign slv_done  = ((state_q == ST_ISSUE) && s_ready_i && (s_resp_valid_i || s_exc_valid_i))
                    || ((state_q == ST_WAIT) && (s_resp_valid_i || s_exc_valid_i));
    assign timed_out = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !slv_done
                    && (cnt_q == 8'(TIMEOUT - 1));

    assign fin_exc  = slv_done ? s_exc_valid_i : 1'b1;
    assign fin_code = slv_done ? (s_exc_valid_i ? s_exc_code_i : 5'd0)
                               : (wr_q ? 5'd7 : 5'd5);
    assign fin_data = (slv_done && !s_exc_valid_i) ? s_data_i : 64'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 8'd0;
            addr_q       <= 64'd0;
            be_q         <= MEM_BYTE;
            wr_q         <= 1'b0;
            ze_q         <= 1'b0;
            wdata_q      <= 64'd0;
            s_valid_q    <= 1'b0;
            m0_resp_q    <= 1'b0;
            m0_exc_q     <= 1'b0;
            m0_data_q    <= 64'd0;
            m0_code_q    <= 5'd0;
            m1_resp_q    <= 1'b0;
            m1_exc_q     <= 1'b0;
            m1_data_q    <= 64'd0;
            m1_code_q    <= 5'd0;
        end else begin
            m0_resp_q <= 1'b0;
            m0_exc_q  <= 1'b0;
            m0_data_q <= 64'd0;
            m0_code_q <= 5'd0;
            m1_resp_q <= 1'b0;
            m1_exc_q  <= 1'b0;
            m1_data_q <= 64'd0;
            m1_code_q <= 5'd0;
            case (state_q)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        addr_q       <= grant1 ? m1_addr_i       : m0_addr_i;
                        be_q         <= grant1 ? m1_byte_en_i    : m0_byte_en_i;
                        wr_q         <= grant1 ? m1_wr_i         : m0_wr_i;
                        ze_q         <= grant1 ? m1_zero_extnd_i : m0_zero_extnd_i;
                        wdata_q      <= grant1 ? m1_wr_data_i    : m0_wr_data_i;
                        owner_q      <= grant1;
                        last_grant_q <= grant1;
                        cnt_q        <= 8'd0;
                        s_valid_q    <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (slv_done || timed_out) begin
                        s_valid_q <= 1'b0;
                        state_q   <= ST_RESP;
                        if (owner_q) begin
                            m1_resp_q <= !fin_exc;
                            m1_exc_q  <= fin_exc;
                            m1_data_q <= fin_data;
                            m1_code_q <= fin_code;
                        end else begin
                            m0_resp_q <= !fin_exc;
                            m0_exc_q  <= fin_exc;
                            m0_data_q <= fin_data;
                            m0_code_q <= fin_code;
                        end
                    end else if ((state_q == ST_ISSUE) && s_ready_i) begin
                        s_valid_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_ready_o      = grant0;
    assign m1_ready_o      = grant1;
    assign m0_resp_valid_o = m0_resp_q;
    assign m0_exc_valid_o  = m0_exc_q;
    assign m0_data_o       = m0_data_q;
    assign m0_exc_code_o   = m0_code_q;
    assign m1_resp_valid_o = m1_resp_q;
    assign m1_exc_valid_o  = m1_exc_q;
    assign m1_data_o       = m1_data_q;
    assign m1_exc_code_o   = m1_code_q;
    assign s_addr_o        = addr_q;
    assign s_valid_o       = s_valid_q;
    assign s_byte_en_o     = be_q;
    assign s_wr_o          = wr_q;
    assign s_zero_extnd_o  = ze_q;
    assign s_wr_data_o     = wdata_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed scenarios plus randomized
// accesses scored against a transaction-level model of arbitration and timing.
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [63:0] f_addr[2];
    logic [63:0] f_wd[2];
    logic [1:0]  f_be[2];
    logic        f_wr[2];
    logic        f_ze[2];
    logic        f_valid[2];

    mem_access_size_t m0_byte_en_i, m1_byte_en_i, s_byte_en_o;
    logic        m0_ready_o, m0_resp_valid_o, m0_exc_valid_o;
    logic        m1_ready_o, m1_resp_valid_o, m1_exc_valid_o;
    logic [63:0] m0_data_o, m1_data_o, s_addr_o, s_wr_data_o;
    logic [4:0]  m0_exc_code_o, m1_exc_code_o;
    logic        s_valid_o, s_wr_o, s_zero_extnd_o;
    logic        s_ready, s_resp, s_exc;
    logic [63:0] s_data;
    logic [4:0]  s_code;
    arb_state_t  dbg_state_o;

    assign m0_byte_en_i = mem_access_size_t'(f_be[0]);
    assign m1_byte_en_i = mem_access_size_t'(f_be[1]);

    mmio_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_addr_i(f_addr[0]), .m0_valid_i(f_valid[0]), .m0_byte_en_i(m0_byte_en_i),
        .m0_wr_i(f_wr[0]), .m0_zero_extnd_i(f_ze[0]), .m0_wr_data_i(f_wd[0]),
        .m0_ready_o(m0_ready_o), .m0_data_o(m0_data_o), .m0_resp_valid_o(m0_resp_valid_o),
        .m0_exc_valid_o(m0_exc_valid_o), .m0_exc_code_o(m0_exc_code_o),
        .m1_addr_i(f_addr[1]), .m1_valid_i(f_valid[1]), .m1_byte_en_i(m1_byte_en_i),
        .m1_wr_i(f_wr[1]), .m1_zero_extnd_i(f_ze[1]), .m1_wr_data_i(f_wd[1]),
        .m1_ready_o(m1_ready_o), .m1_data_o(m1_data_o), .m1_resp_valid_o(m1_resp_valid_o),
        .m1_exc_valid_o(m1_exc_valid_o), .m1_exc_code_o(m1_exc_code_o),
        .s_addr_o(s_addr_o), .s_valid_o(s_valid_o), .s_byte_en_o(s_byte_en_o),
        .s_wr_o(s_wr_o), .s_zero_extnd_o(s_zero_extnd_o), .s_wr_data_o(s_wr_data_o),
        .s_ready_i(s_ready), .s_data_i(s_data), .s_resp_valid_i(s_resp),
        .s_exc_valid_i(s_exc), .s_exc_code_i(s_code),
        .dbg_state_o(dbg_state_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    // Expected completion: {owner, exc, code[4:0], data[63:0]}
    logic [70:0] exp_q[$];
    logic        last_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields;
        for (int i = 0; i < 2; i++) begin
            f_addr[i] = {$urandom, $urandom};
            f_wd[i]   = {$urandom, $urandom};
            f_be[i]   = 2'($urandom_range(0, 3));
            f_wr[i]   = 1'($urandom_range(0, 1));
            f_ze[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m0_out"}, {m0_resp_valid_o, m0_exc_valid_o, m0_exc_code_o, m0_data_o}, 64'd0);
        check({tag, "_m1_out"}, {m1_resp_valid_o, m1_exc_valid_o, m1_exc_code_o, m1_data_o}, 64'd0);
        check({tag, "_s_valid"}, 64'(s_valid_o), 64'd0);
        check({tag, "_state"}, 64'(dbg_state_o), 64'(ST_IDLE));
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        f_valid[0] = 1'b0; f_valid[1] = 1'b0;
        s_ready = 1'b0; s_resp = 1'b0; s_exc = 1'b0; s_data = 64'd0; s_code = 5'd0;
        tick; tick;
        reset = 1'b0;
        last_grant = 1'b1;
    endtask

    // One full access: arbitration, slave behaviour, response and return to idle.
    // rd_dly: cycles s_ready stays low in ISSUE; rsp_dly: cycles from ready to response.
    task automatic do_txn(input logic v0, input logic v1, input int rd_dly, input int rsp_dly,
                          input logic sl_exc, input logic sl_both,
                          input logic [63:0] sl_data, input logic [4:0] sl_code);
        int w, n_ready, n, end_cyc;
        logic [70:0] e;
        logic [63:0] a_addr, a_wd;
        logic [3:0]  a_ctl;
        logic [63:0] o_data;
        logic [4:0]  o_code;
        logic        o_resp, o_exc;
        w = (v0 && v1) ? (last_grant ? 0 : 1) : (v1 ? 1 : 0);
        n_ready = rd_dly + 1;
        n       = n_ready + rsp_dly;
        end_cyc = (n > TIMEOUT) ? TIMEOUT : n;
        if (n > TIMEOUT)   e = {w[0], 1'b1, (f_wr[w] ? 5'd7 : 5'd5), 64'd0};
        else if (sl_exc)   e = {w[0], 1'b1, sl_code, 64'd0};
        else               e = {w[0], 1'b0, 5'd0, sl_data};
        exp_q.push_back(e);
        last_grant = w[0];
        a_addr = f_addr[w];
        a_wd   = f_wd[w];
        a_ctl  = {f_be[w], f_wr[w], f_ze[w]};
        f_valid[0] = v0; f_valid[1] = v1;
        #1;
        check("m0_ready", 64'(m0_ready_o), 64'(w == 0));
        check("m1_ready", 64'(m1_ready_o), 64'(w == 1));
        tick;
        f_valid[0] = 1'b0; f_valid[1] = 1'b0;
        rand_fields;
        for (int c = 1; c <= end_cyc; c++) begin
            check("s_valid", 64'(s_valid_o), 64'(c <= n_ready));
            check("s_addr", s_addr_o, a_addr);
            check("s_wr_data", s_wr_data_o, a_wd);
            check("s_ctl", 64'({s_byte_en_o, s_wr_o, s_zero_extnd_o}), 64'(a_ctl));
            check("early_resp", 64'({m0_resp_valid_o, m0_exc_valid_o, m1_resp_valid_o, m1_exc_valid_o}), 64'd0);
            check("no_ready_busy", 64'({m0_ready_o, m1_ready_o}), 64'd0);
            s_ready = (c == n_ready);
            if (c == n && n <= TIMEOUT) begin
                s_resp = !sl_exc || sl_both;
                s_exc  = sl_exc;
                s_data = sl_data;
                s_code = sl_code;
            end
            tick;
            s_ready = 1'b0; s_resp = 1'b0; s_exc = 1'b0;
            s_data = {$urandom, $urandom}; s_code = 5'd0;
        end
        e = exp_q.pop_front();
        o_resp = e[70] ? m1_resp_valid_o : m0_resp_valid_o;
        o_exc  = e[70] ? m1_exc_valid_o  : m0_exc_valid_o;
        o_code = e[70] ? m1_exc_code_o   : m0_exc_code_o;
        o_data = e[70] ? m1_data_o       : m0_data_o;
        check("resp_valid", 64'(o_resp), 64'(!e[69]));
        check("exc_valid", 64'(o_exc), 64'(e[69]));
        check("exc_code", 64'(o_code), 64'(e[68:64]));
        check("resp_data", o_data, e[63:0]);
        if (e[70])
            check("other_m0", {m0_resp_valid_o, m0_exc_valid_o, m0_exc_code_o, m0_data_o}, 64'd0);
        else
            check("other_m1", {m1_resp_valid_o, m1_exc_valid_o, m1_exc_code_o, m1_data_o}, 64'd0);
        check("resp_s_valid", 64'(s_valid_o), 64'd0);
        tick;
        check_quiet("after_resp");
    endtask

    initial begin
        int v, rd, rs;
        rand_fields;
        apply_reset;
        check_quiet("reset");
        check("reset_s_addr", s_addr_o, 64'd0);
        check("reset_s_wdata", s_wr_data_o, 64'd0);
        check("reset_s_ctl", 64'({s_byte_en_o, s_wr_o, s_zero_extnd_o}), 64'd0);
        #1;
        check("reset_ready", 64'({m0_ready_o, m1_ready_o}), 64'd0);

        // m0 DWORD load answered in the ISSUE cycle
        f_addr[0] = 64'h1BFF8; f_be[0] = 2'd3; f_wr[0] = 1'b0; f_ze[0] = 1'b0;
        do_txn(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 64'h1234, 5'd0);

        // Contention from reset: m0, m1, m0, m1
        apply_reset;
        for (int i = 0; i < 4; i++) begin
            rand_fields;
            do_txn(1'b1, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0,
                   {$urandom, $urandom}, 5'd0);
        end

        // m1 store with slave back-pressure
        rand_fields;
        f_addr[1] = 64'h14000; f_wd[1] = 64'hFFFF; f_wr[1] = 1'b1;
        do_txn(1'b0, 1'b1, 3, 2, 1'b0, 1'b0, {$urandom, $urandom}, 5'd0);

        // Fault together with response: fault wins, data 0
        rand_fields;
        do_txn(1'b1, 1'b0, 0, 1, 1'b1, 1'b1, {$urandom, $urandom}, 5'd5);

        // Watchdog: store in WAIT (code 7), load stuck in ISSUE (code 5)
        rand_fields; f_wr[0] = 1'b1;
        do_txn(1'b1, 1'b0, 0, 100, 1'b0, 1'b0, 64'd0, 5'd0);
        rand_fields;
        do_txn(1'b0, 1'b1, 1, 1, 1'b0, 1'b0, {$urandom, $urandom}, 5'd0);
        rand_fields; f_wr[0] = 1'b0;
        do_txn(1'b1, 1'b0, 40, 0, 1'b0, 1'b0, 64'd0, 5'd0);

        // Response on the last legal cycle versus one cycle late
        rand_fields;
        do_txn(1'b1, 1'b0, 2, TIMEOUT - 3, 1'b0, 1'b0, {$urandom, $urandom}, 5'd0);
        rand_fields;
        do_txn(1'b0, 1'b1, 2, TIMEOUT - 2, 1'b0, 1'b0, {$urandom, $urandom}, 5'd0);

        // Reset while in WAIT
        rand_fields;
        f_valid[0] = 1'b1;
        #1;
        check("rw_ready", 64'(m0_ready_o), 64'd1);
        tick;
        f_valid[0] = 1'b0;
        s_ready = 1'b1;
        tick;
        s_ready = 1'b0;
        check("rw_in_wait", 64'(dbg_state_o), 64'(ST_WAIT));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        last_grant = 1'b1;
        check_quiet("rw_reset");
        check("rw_s_addr", s_addr_o, 64'd0);
        s_resp = 1'b1; s_data = {$urandom, $urandom};
        tick;
        s_resp = 1'b0;
        check_quiet("rw_late_resp");
        rand_fields;
        do_txn(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, {$urandom, $urandom}, 5'd0);

        // Randomized traffic with idle gaps
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                f_valid[0] = 1'b0; f_valid[1] = 1'b0;
                #1;
                check("gap_ready", 64'({m0_ready_o, m1_ready_o}), 64'd0);
                tick;
                check_quiet("gap");
            end
            rand_fields;
            v  = $urandom_range(1, 3);
            rd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
            do_txn(v[0], v[1], rd, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
